ft_sprite_seq: RTL and testbench
================================

FT_SPRITE_SEQ -- requirements
Module: ft_sprite_seq

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  system clock; all state changes on the rising edge.
- VIDEO_RST  in  1  synchronous active-high reset.
- START  in  1  one-cycle pulse that begins a 32-sprite scan.
- SRAM_A  out  7  sprite attribute RAM address, {sprite[4:0], byte[1:0]}.
- SRAM_D  in  8  RAM read data; valid one cycle after SRAM_A.
- SPR_1X  out  9  sprite X position presented to the front-turbo comparator.
- SPR_1Y  out  9  sprite Y position presented to the front-turbo comparator.
- H2n  out  1  active-high one-cycle shift enable for the result shifter.
- H6, H7  out  1 each  register-file byte index (H6 is the LSB).
- WR0  out  1  active-low write strobe, bank 0 (sprites 0-15).
- WR1  out  1  active-low write strobe, bank 1 (sprites 16-31).
- BUSY  out  1  high while a scan is in progress.
- DONE  out  1  one-cycle pulse when a scan completes.

Function
REQ-003 The state machine SHALL have these states: IDLE, RD0, RD1, RD2, CAP, SHIFT, WRITE, FIN.
REQ-004 In IDLE, a START pulse SHALL clear the sprite counter S[4:0] to 0 and move the machine to RD0; BUSY SHALL be 1 from the next cycle.
REQ-005 RD0, RD1 and RD2 SHALL drive SRAM_A = {S,2'd0}, {S,2'd1} and {S,2'd2} respectively; the next state of each is the following state in that order.
REQ-006 The block SHALL capture data as follows:
- In RD1, SRAM_D SHALL be captured as SPR_1Y[7:0].
- In RD2, SRAM_D[0] SHALL be captured as SPR_1Y[8] and SRAM_D[1] as SPR_1X[8].
- In CAP, SRAM_D SHALL be captured as SPR_1X[7:0].
- Byte 3 of each entry SHALL never be read.
REQ-007 SHIFT SHALL assert H2n=1 for exactly one cycle while SPR_1X and SPR_1Y hold that sprite's values, giving the comparator one full settle cycle after CAP.
REQ-008 After SHIFT:
- If S[1:0]==3, the machine SHALL go to WRITE.
- Otherwise S SHALL increment and the machine SHALL go to RD0.
REQ-009 In WRITE, the block SHALL drive {H7,H6}=S[3:2] and pulse WR0=0 (S[4]=0) or WR1=0 (S[4]=1) for exactly one cycle. This is one cycle after the fourth shift, so the shifter holds all 4 results.
REQ-010 After WRITE:
- If S==31, the machine SHALL go to FIN.
- Otherwise S SHALL increment and the machine SHALL go to RD0.
REQ-011 FIN SHALL pulse DONE=1 for one cycle, deassert BUSY, and return to IDLE.
REQ-012 Scan length SHALL be exactly 32*5+8+1 = 169 cycles from the first RD0 to FIN inclusive.
REQ-013 A START pulse while BUSY=1 SHALL be ignored; the scan in progress SHALL be unaffected.
REQ-014 WR0 and WR1 SHALL never be low in the same cycle, and SHALL never be low outside WRITE.
REQ-015 H6 and H7 SHALL hold their last value outside WRITE.
REQ-016 SPR_1X and SPR_1Y SHALL hold their last values between sprites and after DONE.

Reset
REQ-017 VIDEO_RST=1 SHALL force, on the next edge:
- state=IDLE, S=0
- SRAM_A=0
- SPR_1X=0, SPR_1Y=0
- H2n=0, H6=0, H7=0
- WR0=1, WR1=1
- BUSY=0, DONE=0
REQ-018 Reset SHALL override START in the same cycle.
REQ-019 Reset asserted mid-scan SHALL abort the scan with no further strobes and no DONE pulse.

Configuration
REQ-020 Macro FT_SEQ_HIDE_EN SHALL compile in a per-sprite hide feature:
- With the macro defined, when the captured byte-1 bit 7 is 1, SPR_1X and SPR_1Y SHALL both be 9'h1FF during that sprite's CAP and SHIFT cycles. Cycle timing SHALL be unchanged.
- Without the macro, bit 7 SHALL be ignored and the logic SHALL be absent.

Verification
REQ-021 Reset then START, with RAM byte(k)=k: SRAM_A SHALL sequence 0,1,2 then 4,5,6 and so on; BUSY SHALL be high 169 cycles; DONE SHALL pulse once.
REQ-022 Sprite 5 entry {Y=8'h40, b1=8'h03, X=8'h80}: at the H2n cycle, SPR_1Y=9'h140 and SPR_1X=9'h180.
REQ-023 Full scan: exactly 32 H2n pulses and 8 write pulses. WR0 SHALL be low at {H7,H6}=0,1,2,3 (sprites 3,7,11,15); WR1 SHALL be low at 0,1,2,3 (sprites 19,23,27,31). Each write SHALL come one cycle after its H2n.
REQ-024 START re-pulsed at cycle 50 of a scan: the trace SHALL be identical to a single-START run.
REQ-025 VIDEO_RST asserted at cycle 100: WR0=WR1=1, H2n=0, BUSY=0 next cycle; no DONE; a following START SHALL restart at SRAM_A=0.
REQ-026 FT_SEQ_HIDE_EN defined, sprite 2 byte1=8'h80: SPR_1X=SPR_1Y=9'h1FF at sprite 2's H2n; undefined: the RAM values SHALL be presented.

Source files
------------

// File: rtl/ft_sprite_seq.sv
// ---------------------------------------------------------------------------
// ft_sprite_seq -- front-turbo sprite attribute scan sequencer
//
// Purpose:
//   On a START pulse, walks all 32 sprite entries of the attribute RAM.
//   For each sprite it reads bytes 0..2 (byte 3 is never addressed),
//   assembles the 9-bit X/Y position and holds it steady for the
//   front-turbo comparator. It then issues a one-cycle shift enable
//   (H2n). After every fourth sprite, a one-cycle active-low write
//   strobe (WR0 for sprites 0-15, WR1 for sprites 16-31) is issued with
//   the register-file byte index on {H7,H6}.
//
//   Per-sprite timing: RD0, RD1, RD2, CAP, SHIFT (5 cycles). Every fourth
//   sprite adds one WRITE cycle. A single FIN cycle ends the scan, which
//   lasts 32*5 + 8 + 1 = 169 cycles.
//
// Attribute entry layout (byte index within the 4-byte entry):
//   byte 0 : Y[7:0]
//   byte 1 : bit0 = Y[8], bit1 = X[8], bit7 = hide (only with the hide build)
//   byte 2 : X[7:0]
//   byte 3 : unused, never read
//
// Ports:
//   clk        in   1  system clock, rising edge
//   VIDEO_RST  in   1  synchronous active-high reset
//   START      in   1  one-cycle pulse, begins a scan (ignored while BUSY)
//   SRAM_A     out  7  attribute RAM address {sprite[4:0], byte[1:0]}
//   SRAM_D     in   8  attribute RAM read data, valid one cycle after SRAM_A
//   SPR_1X     out  9  sprite X position to the comparator
//   SPR_1Y     out  9  sprite Y position to the comparator
//   H2n        out  1  active-high one-cycle shift enable
//   H6, H7     out  1  register-file byte index (H6 = LSB), held outside WRITE
//   WR0        out  1  active-low write strobe, bank 0 (sprites 0-15)
//   WR1        out  1  active-low write strobe, bank 1 (sprites 16-31)
//   BUSY       out  1  high from the first RD0 through FIN
//   DONE       out  1  one-cycle pulse in the FIN cycle
//
// Build option:
//   FT_SEQ_HIDE_EN -- when defined, a sprite whose byte 1 has bit 7 set
//   presents 9'h1FF on both SPR_1X and SPR_1Y during its CAP and SHIFT
//   cycles. Timing is identical with or without the option.
// ---------------------------------------------------------------------------
module ft_sprite_seq (
  input  logic       clk,
  input  logic       VIDEO_RST,
  input  logic       START,
  output logic [6:0] SRAM_A,
  input  logic [7:0] SRAM_D,
  output logic [8:0] SPR_1X,
  output logic [8:0] SPR_1Y,
  output logic       H2n,
  output logic       H6,
  output logic       H7,
  output logic       WR0,
  output logic       WR1,
  output logic       BUSY,
  output logic       DONE
);

  // -------------------------------------------------------------------------
  // State encoding
  // -------------------------------------------------------------------------
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RD0   = 3'd1;
  localparam logic [2:0] ST_RD1   = 3'd2;
  localparam logic [2:0] ST_RD2   = 3'd3;
  localparam logic [2:0] ST_CAP   = 3'd4;
  localparam logic [2:0] ST_SHIFT = 3'd5;
  localparam logic [2:0] ST_WRITE = 3'd6;
  localparam logic [2:0] ST_FIN   = 3'd7;

  localparam logic [4:0] LAST_SPRITE = 5'd31;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [2:0] state_reg;
  logic [2:0] state_next;
  logic [4:0] s_reg;        // sprite counter
  logic [4:0] s_next;
  logic [6:0] sram_a_reg;
  logic [6:0] sram_a_next;
  logic [8:0] spr_x_reg;
  logic [8:0] spr_y_reg;
  logic [1:0] h_idx_reg;    // {H7,H6}

  // Bits of SRAM_D that carry no meaning in this build; folded into a
  // single sink so the unused byte-1 bits are explicitly acknowledged.
  logic unused_sram_bits;
  assign unused_sram_bits = ^SRAM_D[7:2];

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    s_next     = s_reg;
    case (state_reg)
      ST_IDLE: begin
        if (START) begin
          s_next     = 5'd0;
          state_next = ST_RD0;
        end
      end
      ST_RD0:  state_next = ST_RD1;
      ST_RD1:  state_next = ST_RD2;
      ST_RD2:  state_next = ST_CAP;
      ST_CAP:  state_next = ST_SHIFT;
      ST_SHIFT: begin
        // Fourth sprite of a group: the shifter now holds four results,
        // so commit them before moving on.
        if (s_reg[1:0] == 2'd3) begin
          state_next = ST_WRITE;
        end else begin
          s_next     = 5'(s_reg + 5'd1);
          state_next = ST_RD0;
        end
      end
      ST_WRITE: begin
        if (s_reg == LAST_SPRITE) begin
          state_next = ST_FIN;
        end else begin
          s_next     = 5'(s_reg + 5'd1);
          state_next = ST_RD0;
        end
      end
      ST_FIN:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Address generation
  // The address is registered from the next state, so it is valid for the
  // whole RDx cycle and the RAM data arrives in the following cycle. Outside
  // the read states the last address is held.
  // -------------------------------------------------------------------------
  always_comb begin
    sram_a_next = sram_a_reg;
    case (state_next)
      ST_RD0:  sram_a_next = {s_next, 2'd0};
      ST_RD1:  sram_a_next = {s_next, 2'd1};
      ST_RD2:  sram_a_next = {s_next, 2'd2};
      default: sram_a_next = sram_a_reg;
    endcase
  end

  // -------------------------------------------------------------------------
  // Sequential state, address and index registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (VIDEO_RST) begin
      state_reg  <= ST_IDLE;
      s_reg      <= 5'd0;
      sram_a_reg <= 7'd0;
      h_idx_reg  <= 2'd0;
    end else begin
      state_reg  <= state_next;
      s_reg      <= s_next;
      sram_a_reg <= sram_a_next;
      // Index is loaded on entry to WRITE and held afterwards.
      if (state_next == ST_WRITE) begin
        h_idx_reg <= s_reg[3:2];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Position capture
  // Data for the address driven in RDn arrives in the next state:
  //   RD1 sees byte 0 (Y low), RD2 sees byte 1 (MSBs), CAP sees byte 2 (X low).
  // The registers simply hold between sprites and after the scan.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (VIDEO_RST) begin
      spr_x_reg <= 9'd0;
      spr_y_reg <= 9'd0;
    end else begin
      case (state_reg)
        ST_RD1: begin
          spr_y_reg[7:0] <= SRAM_D;
        end
        ST_RD2: begin
          spr_y_reg[8] <= SRAM_D[0];
          spr_x_reg[8] <= SRAM_D[1];
        end
        ST_CAP: begin
          spr_x_reg[7:0] <= SRAM_D;
        end
        default: ;
      endcase
    end
  end

`ifdef FT_SEQ_HIDE_EN
  // -------------------------------------------------------------------------
  // Hide option: byte-1 bit 7 is latched alongside the MSBs and forces the
  // comparator inputs to all-ones while that sprite is being compared.
  // The underlying position registers still capture the real values.
  // -------------------------------------------------------------------------
  logic hide_reg;
  logic hide_active;

  always_ff @(posedge clk) begin
    if (VIDEO_RST) begin
      hide_reg <= 1'b0;
    end else if (state_reg == ST_RD2) begin
      hide_reg <= SRAM_D[7];
    end
  end

  assign hide_active = hide_reg &&
                       ((state_reg == ST_CAP) || (state_reg == ST_SHIFT));

  assign SPR_1X = hide_active ? 9'h1FF : spr_x_reg;
  assign SPR_1Y = hide_active ? 9'h1FF : spr_y_reg;
`else
  assign SPR_1X = spr_x_reg;
  assign SPR_1Y = spr_y_reg;
`endif

  // -------------------------------------------------------------------------
  // Strobes and status
  // All are pure decodes of registered state, so reset drives them to their
  // idle levels on the same edge that returns the machine to IDLE.
  // -------------------------------------------------------------------------
  logic       in_write;
  logic [1:0] wr_n;

  assign in_write = (state_reg == ST_WRITE);

  // Bank select by sprite MSB; at most one bank strobe can be low at a time.
  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    assign wr_n[gi] = ~(in_write && (s_reg[4] == 1'(gi)));
  end

  assign WR0    = wr_n[0];
  assign WR1    = wr_n[1];
  assign H2n    = (state_reg == ST_SHIFT);
  assign BUSY   = (state_reg != ST_IDLE);
  assign DONE   = (state_reg == ST_FIN);
  assign SRAM_A = sram_a_reg;
  assign H6     = h_idx_reg[0];
  assign H7     = h_idx_reg[1];

endmodule

// File: tb/tb_ft_sprite_seq.sv
module tb_ft_sprite_seq;

  logic       clk = 1'b0;
  logic       VIDEO_RST;
  logic       START;
  logic [6:0] SRAM_A;
  logic [7:0] SRAM_D;
  logic [8:0] SPR_1X;
  logic [8:0] SPR_1Y;
  logic       H2n, H6, H7, WR0, WR1, BUSY, DONE;

  always #5 clk = ~clk;

  ft_sprite_seq dut (
    .clk       (clk),
    .VIDEO_RST (VIDEO_RST),
    .START     (START),
    .SRAM_A    (SRAM_A),
    .SRAM_D    (SRAM_D),
    .SPR_1X    (SPR_1X),
    .SPR_1Y    (SPR_1Y),
    .H2n       (H2n),
    .H6        (H6),
    .H7        (H7),
    .WR0       (WR0),
    .WR1       (WR1),
    .BUSY      (BUSY),
    .DONE      (DONE)
  );

  // Attribute RAM model: registered read, data valid one cycle after address.
  logic [7:0] mem [0:127];
  always @(posedge clk) SRAM_D <= mem[SRAM_A];

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct { logic [8:0] x; logic [8:0] y; } spr_t;
  typedef struct { logic bank; logic [1:0] idx; } wr_t;
  spr_t h2n_q[$];
  wr_t  wr_q[$];
  spr_t mon_spr;
  wr_t  mon_wr;

  int   done_count = 0;
  logic mon_en     = 1'b0;
  logic prev_h2n   = 1'b0;

  int cyc, restart_cyc, rst_cyc;
  bit aborted;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected comparator inputs for sprite s, derived from the RAM image.
  function automatic spr_t exp_spr(input int s);
    spr_t r;
    logic [7:0] b0, b1, b2;
    b0 = mem[4*s];
    b1 = mem[4*s+1];
    b2 = mem[4*s+2];
    r.y = {b1[0], b0};
    r.x = {b1[1], b2};
`ifdef FT_SEQ_HIDE_EN
    if (b1[7]) begin
      r.x = 9'h1FF;
      r.y = 9'h1FF;
    end
`endif
    return r;
  endfunction

  task automatic push_expect();
    wr_t w;
    for (int s = 0; s < 32; s++) begin
      h2n_q.push_back(exp_spr(s));
      if (s % 4 == 3) begin
        w.bank = (s >= 16);
        w.idx  = 2'((s / 4) % 4);
        wr_q.push_back(w);
      end
    end
  endtask

  // Scoreboard side: pops expectations when the DUT produces H2n / writes.
  always @(negedge clk) begin
    if (mon_en) begin
      if (BUSY === 1'b1)
        chk("byte3_never_read", {31'd0, SRAM_A[1:0] == 2'd3}, 32'd0);
      if (WR0 === 1'b0 && WR1 === 1'b0)
        chk("wr_exclusive", 32'd1, 32'd0);
      if (H2n === 1'b1) begin
        if (h2n_q.size() == 0) begin
          chk("h2n_unexpected", 32'd1, 32'd0);
        end else begin
          mon_spr = h2n_q.pop_front();
          chk("spr_x_at_h2n", {23'd0, SPR_1X}, {23'd0, mon_spr.x});
          chk("spr_y_at_h2n", {23'd0, SPR_1Y}, {23'd0, mon_spr.y});
        end
      end
      if (WR0 === 1'b0 || WR1 === 1'b0) begin
        chk("wr_after_h2n", {31'd0, prev_h2n}, 32'd1);
        if (wr_q.size() == 0) begin
          chk("wr_unexpected", 32'd1, 32'd0);
        end else begin
          mon_wr = wr_q.pop_front();
          chk("wr_bank", {31'd0, WR1 === 1'b0}, {31'd0, mon_wr.bank});
          chk("wr_idx", {30'd0, H7, H6}, {30'd0, mon_wr.idx});
          $display("write bank=%0d idx=%0d", WR1 === 1'b0, {H7, H6});
        end
      end
      if (DONE === 1'b1) done_count++;
    end
    prev_h2n <= (H2n === 1'b1);
  end

  // One scan cycle: check the per-cycle outputs, optionally inject a START or
  // a reset, then advance.
  task automatic scan_cycle(input logic [6:0] a, input logic h, input logic w0,
                            input logic w1, input logic d);
    if (aborted) return;
    chk("sram_a", {25'd0, SRAM_A}, {25'd0, a});
    chk("h2n",    {31'd0, H2n},  {31'd0, h});
    chk("wr0",    {31'd0, WR0},  {31'd0, w0});
    chk("wr1",    {31'd0, WR1},  {31'd0, w1});
    chk("busy",   {31'd0, BUSY}, 32'd1);
    chk("done",   {31'd0, DONE}, {31'd0, d});
    if (cyc == restart_cyc) START = 1'b1;
    if (cyc == rst_cyc) VIDEO_RST = 1'b1;
    tick();
    START = 1'b0;
    if (VIDEO_RST) begin
      VIDEO_RST = 1'b0;
      aborted   = 1'b1;
    end
    cyc++;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_sram_a"}, {25'd0, SRAM_A}, 32'd0);
    chk({tag, "_spr_x"},  {23'd0, SPR_1X}, 32'd0);
    chk({tag, "_spr_y"},  {23'd0, SPR_1Y}, 32'd0);
    chk({tag, "_h2n"},    {31'd0, H2n}, 32'd0);
    chk({tag, "_h76"},    {30'd0, H7, H6}, 32'd0);
    chk({tag, "_wr0"},    {31'd0, WR0}, 32'd1);
    chk({tag, "_wr1"},    {31'd0, WR1}, 32'd1);
    chk({tag, "_busy"},   {31'd0, BUSY}, 32'd0);
    chk({tag, "_done"},   {31'd0, DONE}, 32'd0);
  endtask

  task automatic run_scan(input string name, input int rs_at, input int rst_at);
    int   d0;
    logic [7:0] b1;
    restart_cyc = rs_at;
    rst_cyc     = rst_at;
    aborted     = 1'b0;
    cyc         = 0;
    d0          = done_count;
    chk({name, "_idle_busy"}, {31'd0, BUSY}, 32'd0);
    push_expect();
    START = 1'b1;
    tick();
    START = 1'b0;
    for (int s = 0; s < 32; s++) begin
      for (int p = 0; p < 5; p++)
        scan_cycle({s[4:0], (p < 3) ? p[1:0] : 2'd2}, p == 4, 1'b1, 1'b1, 1'b0);
      if (s % 4 == 3)
        scan_cycle({s[4:0], 2'd2}, 1'b0, s >= 16, s < 16, 1'b0);
    end
    scan_cycle({5'd31, 2'd2}, 1'b0, 1'b1, 1'b1, 1'b1);
    if (!aborted) begin
      b1 = mem[125];
      chk({name, "_busy_after"}, {31'd0, BUSY}, 32'd0);
      chk({name, "_done_after"}, {31'd0, DONE}, 32'd0);
      chk({name, "_done_pulses"}, done_count - d0, 32'd1);
      chk({name, "_h2n_q_empty"}, h2n_q.size(), 32'd0);
      chk({name, "_wr_q_empty"}, wr_q.size(), 32'd0);
      chk({name, "_hold_x"}, {23'd0, SPR_1X}, {23'd0, b1[1], mem[126]});
      chk({name, "_hold_y"}, {23'd0, SPR_1Y}, {23'd0, b1[0], mem[124]});
      chk({name, "_hold_h76"}, {30'd0, H7, H6}, 32'd3);
    end else begin
      check_reset_state({name, "_abort"});
      tick();
      tick();
      chk({name, "_no_done"}, done_count - d0, 32'd0);
      chk({name, "_abort_wr0"}, {31'd0, WR0}, 32'd1);
      chk({name, "_abort_busy"}, {31'd0, BUSY}, 32'd0);
      h2n_q.delete();
      wr_q.delete();
    end
    $display("scan %s complete at cycle %0d aborted=%0d", name, cyc, aborted);
  endtask

  initial begin
    VIDEO_RST = 1'b1;
    START     = 1'b1;
    for (int k = 0; k < 128; k++) mem[k] = 8'(k);
    tick();
    tick();
    // Reset held with START high: reset wins.
    check_reset_state("reset");
    VIDEO_RST = 1'b0;
    START     = 1'b0;
    tick();
    chk("post_reset_busy", {31'd0, BUSY}, 32'd0);
    chk("post_reset_sram_a", {25'd0, SRAM_A}, 32'd0);
    mon_en = 1'b1;

    // Scan 1: byte(k) = k.
    run_scan("ramp", -1, -1);

    // Scan 2: random contents with directed sprite 5 and sprite 2 entries.
    for (int k = 0; k < 128; k++) mem[k] = 8'($urandom);
    mem[20] = 8'h40;
    mem[21] = 8'h03;
    mem[22] = 8'h80;
    mem[9]  = 8'h80;
    run_scan("rand", -1, -1);

    // Scan 3: START re-pulsed mid-scan must be ignored.
    run_scan("restart", 50, -1);

    // Scan 4: reset at cycle 100 aborts; scan 5 restarts from address 0.
    run_scan("abort", -1, 100);
    run_scan("after_abort", -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Global time bound so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
